// File: rtl/mant_mul_norm.sv
// Sequential single-precision mantissa multiplier: 24-cycle shift-add product,
// normalise, round-to-nearest-even, range check and IEEE-754 pack.
module mant_mul_norm #(
    parameter int MANT_W = 23,
    parameter int EXP_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     sign_A,
    input  logic                     sign_B,
    input  logic [MANT_W-1:0]        mant_A,
    input  logic [MANT_W-1:0]        mant_B,
    input  logic [EXP_W+1:0]         exp_in,
    input  logic                     is_zero,
    input  logic                     is_inf,
    input  logic                     is_nan,
    output logic [EXP_W+MANT_W:0]    result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int SIG_W = MANT_W + 1;
    localparam int PW    = 2 * SIG_W;
    localparam int CNT_W = $clog2(SIG_W);
    localparam int XW    = EXP_W + 3;
    localparam int RW    = EXP_W + MANT_W + 1;
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t                    state_q, state_d;
    logic                      sign_q, sign_d;
    logic [SIG_W-1:0]          a_q, a_d, b_q, b_d;
    logic signed [EXP_W+1:0]   exp_q, exp_d;
    logic [PW-1:0]             p_q, p_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      ph_q, ph_d;
    logic [MANT_W-1:0]         frac_q, frac_d;
    logic                      g_q, g_d, s_q, s_d;
    logic signed [XW-1:0]      nexp_q, nexp_d;
    logic [RW-1:0]             result_q, result_d;
    logic                      ovf_q, ovf_d, unf_q, unf_d;

    logic [MANT_W:0]           frac_r;
    logic signed [XW-1:0]      exp_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            exp_q    <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            ph_q     <= 1'b0;
            frac_q   <= '0;
            g_q      <= 1'b0;
            s_q      <= 1'b0;
            nexp_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            a_q      <= a_d;
            b_q      <= b_d;
            exp_q    <= exp_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            ph_q     <= ph_d;
            frac_q   <= frac_d;
            g_q      <= g_d;
            s_q      <= s_d;
            nexp_q   <= nexp_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        a_d      = a_q;
        b_d      = b_q;
        exp_d    = exp_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        ph_d     = ph_q;
        frac_d   = frac_q;
        g_d      = g_q;
        s_d      = s_q;
        nexp_d   = nexp_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        frac_r   = {1'b0, frac_q} + {{MANT_W{1'b0}}, g_q & (s_q | frac_q[0])};
        exp_r    = nexp_q + {{(XW-1){1'b0}}, frac_r[MANT_W]};

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = sign_A ^ sign_B;
                    a_d    = {1'b1, mant_A};
                    b_d    = {1'b1, mant_B};
                    exp_d  = exp_in;
                    p_d    = '0;
                    cnt_d  = '0;
                    ph_d   = 1'b0;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    state_d = DONE;
                    if (is_nan)
                        result_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
                    else if (is_inf)
                        result_d = {sign_A ^ sign_B, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                    else if (is_zero)
                        result_d = {sign_A ^ sign_B, {(RW-1){1'b0}}};
                    else
                        state_d = MUL;
                end
            end
            MUL: begin
                if (b_q[cnt_q])
                    p_d = p_q + (PW'(a_q) << cnt_q);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(SIG_W - 1))
                    state_d = NORM;
            end
            NORM: begin
                // Two sub-phases: normalise into registers, then round and pack.
                if (!ph_q) begin
                    if (p_q[PW-1]) begin
                        frac_d = p_q[PW-2 -: MANT_W];
                        g_d    = p_q[PW-2-MANT_W];
                        s_d    = |p_q[PW-3-MANT_W:0];
                    end else begin
                        frac_d = p_q[PW-3 -: MANT_W];
                        g_d    = p_q[PW-3-MANT_W];
                        s_d    = |p_q[PW-4-MANT_W:0];
                    end
                    nexp_d = XW'(exp_q) + {{(XW-1){1'b0}}, p_q[PW-1]};
                    ph_d   = 1'b1;
                end else begin
                    if (exp_r >= EXP_MAX) begin
                        result_d = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                        ovf_d    = 1'b1;
                    end else if (exp_r[XW-1] || exp_r == '0) begin
                        result_d = {sign_q, {(RW-1){1'b0}}};
                        unf_d    = 1'b1;
                    end else begin
                        result_d = {sign_q, exp_r[EXP_W-1:0], frac_r[MANT_W-1:0]};
                    end
                    ph_d    = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_mant_mul_norm.sv
// Table-driven bench for mant_mul_norm with an expected-result queue,
// plus hand-written hold and mid-operation reset sequences.
module tb_mant_mul_norm;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic        sign_A, sign_B;
    logic [22:0] mant_A, mant_B;
    logic [9:0]  exp_in;
    logic        is_zero, is_inf, is_nan;
    logic [31:0] result;
    logic        out_valid, out_ready;
    logic        overflow, underflow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        sa, sb;
        logic [22:0] ma, mb;
        logic [9:0]  ex;
        logic        n, i, z;
        logic [31:0] res;
        logic        ov, un;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ov, un;
    } exp_t;

    vec_t tbl[18];
    exp_t sb[$];

    mant_mul_norm #(.MANT_W(23), .EXP_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sign_A(sign_A), .sign_B(sign_B), .mant_A(mant_A), .mant_B(mant_B),
        .exp_in(exp_in), .is_zero(is_zero), .is_inf(is_inf), .is_nan(is_nan),
        .result(result), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic sa, logic sb, logic [22:0] ma, logic [22:0] mb,
                                logic [9:0] ex, logic n, logic i, logic z,
                                logic [31:0] res, logic ov, logic un);
        vec_t v;
        v.sa = sa; v.sb = sb; v.ma = ma; v.mb = mb; v.ex = ex;
        v.n = n; v.i = i; v.z = z; v.res = res; v.ov = ov; v.un = un;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic send(input vec_t v);
        exp_t e;
        @(negedge clk);
        sign_A = v.sa; sign_B = v.sb; mant_A = v.ma; mant_B = v.mb; exp_in = v.ex;
        is_nan = v.n; is_inf = v.i; is_zero = v.z; in_valid = 1'b1;
        @(posedge clk);
        e.res = v.res; e.ov = v.ov; e.un = v.un;
        sb.push_back(e);
        #1;
        in_valid = 1'b0;
        sign_A = 1'($urandom); sign_B = 1'($urandom);
        mant_A = 23'($urandom); mant_B = 23'($urandom); exp_in = 10'($urandom);
        is_nan = 1'($urandom); is_inf = 1'($urandom); is_zero = 1'($urandom);
    endtask

    task automatic collect(input string tag, input int exp_lat, input int hold);
        int n;
        exp_t e;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!out_valid && n < 60);
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'(0), 32'(1));
            return;
        end
        e = sb.pop_front();
        chk({tag, "_result"}, result, e.res);
        chk({tag, "_ovf_unf"}, {30'b0, overflow, underflow}, {30'b0, e.ov, e.un});
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            mant_A = 23'($urandom); mant_B = 23'($urandom);
            @(negedge clk);
            chk({tag, "_hold_result"}, result, e.res);
            chk({tag, "_hold_ready_valid"}, {30'b0, in_ready, out_valid}, 32'h1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_back_idle"}, {30'b0, in_ready, out_valid}, 32'h2);
    endtask

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        sign_A = 1'b0; sign_B = 1'b0; mant_A = '0; mant_B = '0; exp_in = '0;
        is_zero = 1'b0; is_inf = 1'b0; is_nan = 1'b0;

        tbl[0]  = mk(0,0,23'h400000,23'h400000,10'd127,0,0,0,32'h40100000,0,0);
        tbl[1]  = mk(0,0,23'h000001,23'h000001,10'd127,0,0,0,32'h3F800002,0,0);
        tbl[2]  = mk(0,0,23'h000000,23'h000000,10'd127,0,0,0,32'h3F800000,0,0);
        tbl[3]  = mk(1,0,23'h7FFFFF,23'h7FFFFF,10'd254,0,0,0,32'hFF800000,1,0);
        tbl[4]  = mk(1,0,23'h000000,23'h000000,10'd0,  0,0,0,32'h80000000,0,1);
        tbl[5]  = mk(0,0,23'h123456,23'h654321,10'd127,1,0,0,32'h7FC00000,0,0);
        tbl[6]  = mk(1,1,23'h000000,23'h000000,10'd300,0,1,0,32'h7F800000,0,0);
        tbl[7]  = mk(1,0,23'h000000,23'h000000,10'd127,0,0,1,32'h80000000,0,0);
        tbl[8]  = mk(1,0,23'h000000,23'h000000,10'd127,1,1,0,32'h7FC00000,0,0);
        tbl[9]  = mk(1,0,23'h000000,23'h000000,10'd127,0,1,1,32'hFF800000,0,0);
        tbl[10] = mk(0,0,23'h000001,23'h400000,10'd127,0,0,0,32'h3FC00002,0,0);
        tbl[11] = mk(0,0,23'h000800,23'h000800,10'd127,0,0,0,32'h3F801000,0,0);
        tbl[12] = mk(0,0,23'h000800,23'h000801,10'd127,0,0,0,32'h3F801002,0,0);
        tbl[13] = mk(0,0,23'h000000,23'h000000,10'd254,0,0,0,32'h7F000000,0,0);
        tbl[14] = mk(0,0,23'h000000,23'h000000,10'd1,  0,0,0,32'h00800000,0,0);
        tbl[15] = mk(0,0,23'h400000,23'h400000,10'd254,0,0,0,32'h7F800000,1,0);
        tbl[16] = mk(0,0,23'h000000,23'h000000,10'h3FB,0,0,0,32'h00000000,0,1);
        tbl[17] = mk(1,1,23'h400000,23'h000000,10'd130,0,0,0,32'h41400000,0,0);

        #1;
        chk("reset_result", result, 32'h0);
        chk("reset_flags", {28'b0, in_ready, out_valid, overflow, underflow}, 32'h8);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        foreach (tbl[idx]) begin
            send(tbl[idx]);
            collect($sformatf("vec%0d", idx),
                    (tbl[idx].n || tbl[idx].i || tbl[idx].z) ? 1 : 26, 0);
        end

        // Result held through 5 stalled cycles with a competing request.
        send(tbl[0]);
        collect("hold", 26, 5);

        // Asynchronous reset in the middle of MUL abandons the operation.
        send(tbl[3]);
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_state", {29'b0, in_ready, out_valid, overflow}, 32'h4);
        chk("midrst_result", result, 32'h0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_result_after_rst", 32'(seen), 32'h0);
        send(tbl[10]);
        collect("after_rst", 26, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
